blake2s_block_loader: RTL and testbench

//  Upstream stage of the BLAKE2s message-word select logic. Accepts the message as a big-endian
//  32-bit word stream over valid/ready and assembles 512-bit zero-padded blocks.

---
 rtl/blake2s_pkg.sv | 9 +
 rtl/blake2s_word_mask.sv | 25 ++
 rtl/blake2s_block_loader.sv | 169 ++++++++++++++++
 tb/tb_blake2s_block_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2s_pkg.sv
// Shared constants for the BLAKE2s message front end.
// Block geometry and the default width of the byte counter t.
package blake2s_pkg;

    localparam int BLOCK_WORDS   = 16;
    localparam int BLOCK_BYTES   = 64;
    localparam int DEF_CNT_WIDTH = 64;

endpackage

// File: rtl/blake2s_word_mask.sv
// Zeroes the bytes of a big-endian message word beyond its valid byte count.
// A non-last word, or a byte count above 4, always counts as a full word.
module blake2s_word_mask (
    input  logic [31:0] data_i,
    input  logic        last_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] data_o,
    output logic [2:0]  bytes_o
);

    always_comb begin
        bytes_o = 3'd4;
        data_o  = '0;
        if (last_i && (bytes_i < 3'd4)) begin
            bytes_o = bytes_i;
        end
        // Byte lane j sits at [31-8j -: 8]; lane 0 is the first message byte.
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < bytes_o) begin
                data_o[31-8*j -: 8] = data_i[31-8*j -: 8];
            end
        end
    end

endmodule

// File: rtl/blake2s_block_loader.sv
// Packs a 32-bit big-endian word stream into zero-padded 512-bit BLAKE2s blocks.
// A full block is held until the following word shows whether it is the final one.
//
// Handshakes: a word moves on posedge clk when in_valid & in_ready are both 1, and a block
// moves when blk_valid & blk_ready are both 1. in_ready and blk_valid are registered and
// depend on the FSM state only. Once blk_valid is 1, blk_m, blk_final and blk_t hold
// their values until the block handshake.
module blake2s_block_loader
    import blake2s_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    input  logic [2:0]           in_bytes,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [511:0]         blk_m,
    output logic                 blk_final,
    output logic [CNT_WIDTH-1:0] blk_t,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HOLD = 2'd1,
        S_EMIT = 2'd2
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_WORDS - 1);

    state_e                          state_q, state_d;
    logic [BLOCK_WORDS-1:0][31:0]    buf_q, buf_d;
    logic [3:0]                      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]            t_q, t_d;
    logic                            final_q, final_d;
    logic [31:0]                     carry_q, carry_d;
    logic [2:0]                      carry_bytes_q, carry_bytes_d;
    logic                            carry_valid_q, carry_valid_d;
    logic                            carry_last_q, carry_last_d;
    logic                            in_ready_q;
    logic                            blk_valid_q;

    logic [31:0] m_data;
    logic [2:0]  m_bytes;
    logic        accept;

    blake2s_word_mask u_mask (
        .data_i  (in_data),
        .last_i  (in_last),
        .bytes_i (in_bytes),
        .data_o  (m_data),
        .bytes_o (m_bytes)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        idx_d         = idx_q;
        t_d           = t_q;
        final_d       = final_q;
        carry_d       = carry_q;
        carry_bytes_d = carry_bytes_q;
        carry_valid_d = carry_valid_q;
        carry_last_d  = carry_last_q;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    // Word k of the block occupies packed slot 15-k, i.e. [511-32k -: 32].
                    buf_d[LAST_IDX - idx_q] = m_data;
                    t_d = t_q + CNT_WIDTH'(m_bytes);
                    if (in_last) begin
                        final_d = 1'b1;
                        state_d = S_EMIT;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    if (in_last && (m_bytes == 3'd0)) begin
                        final_d = 1'b1;
                    end else begin
                        carry_d       = m_data;
                        carry_bytes_d = m_bytes;
                        carry_last_d  = in_last;
                        carry_valid_d = 1'b1;
                        final_d       = 1'b0;
                    end
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (blk_valid_q && blk_ready) begin
                    buf_d   = '0;
                    final_d = 1'b0;
                    if (carry_valid_q) begin
                        // The held-back word opens the next block and is counted only now.
                        buf_d[LAST_IDX] = carry_q;
                        t_d             = t_q + CNT_WIDTH'(carry_bytes_q);
                        idx_d           = 4'd1;
                        carry_valid_d   = 1'b0;
                        if (carry_last_q) begin
                            final_d = 1'b1;
                            state_d = S_EMIT;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        if (final_q) begin
                            t_d = '0;
                        end
                        idx_d   = 4'd0;
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            buf_q         <= '0;
            idx_q         <= 4'd0;
            t_q           <= '0;
            final_q       <= 1'b0;
            carry_q       <= '0;
            carry_bytes_q <= 3'd0;
            carry_valid_q <= 1'b0;
            carry_last_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            idx_q         <= idx_d;
            t_q           <= t_d;
            final_q       <= final_d;
            carry_q       <= carry_d;
            carry_bytes_q <= carry_bytes_d;
            carry_valid_q <= carry_valid_d;
            carry_last_q  <= carry_last_d;
            in_ready_q    <= (state_d != S_EMIT);
            blk_valid_q   <= (state_d == S_EMIT);
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_m     = buf_q;
    assign blk_final = final_q;
    assign blk_t     = t_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_blake2s_block_loader.sv
// Random and directed message streams for blake2s_block_loader, checked against a
// byte-level block model computed directly from the message contents.
module tb_blake2s_block_loader;

    typedef logic [7:0] msg_t[$];

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_m;
    logic         blk_final;
    logic [63:0]  blk_t;
    logic [1:0]   state_o;

    logic [576:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           cons_hold = 1'b1;

    blake2s_block_loader #(.CNT_WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_m     (blk_m),
        .blk_final (blk_final),
        .blk_t     (blk_t),
        .state_o   (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: the message split into 64-byte chunks, each zero padded, t = bytes so far.
    function automatic void model(input msg_t msg);
        int len  = msg.size();
        int nblk = (len == 0) ? 1 : (len + 63) / 64;
        for (int b = 0; b < nblk; b++) begin
            logic [511:0] m = '0;
            int t;
            for (int i = b * 64; i < len && i < (b + 1) * 64; i++) begin
                m[511 - 8 * (i - b * 64) -: 8] = msg[i];
            end
            t = (len < (b + 1) * 64) ? len : (b + 1) * 64;
            exp_q.push_back({(b == nblk - 1), 64'(t), m});
        end
    endfunction

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int cnt = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) check("in_ready_timeout", 512'(in_ready), 512'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input msg_t msg, input bit extra);
        int len = msg.size();
        int nw  = (len + 3) / 4;
        model(msg);
        if (len == 0) send_word($urandom, 1'b1, 3'd0);
        for (int k = 0; k < nw; k++) begin
            int          nb = (len - 4 * k >= 4) ? 4 : len - 4 * k;
            logic        last = (k == nw - 1) && !extra;
            logic [31:0] w = $urandom;
            for (int j = 0; j < nb; j++) w[31 - 8 * j -: 8] = msg[4 * k + j];
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            send_word(w, last, last ? 3'(nb) : 3'($urandom_range(0, 4)));
        end
        if (extra && len > 0) send_word($urandom, 1'b1, 3'd0);
    endtask

    task automatic wait_done();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("blocks_pending", 512'(exp_q.size()), 512'(0));
        @(negedge clk);
        check("in_ready_after_final", 512'(in_ready), 512'(1));
        repeat (4) @(negedge clk);
    endtask

    task automatic run_msg(input msg_t msg, input bit extra);
        send_msg(msg, extra);
        wait_done();
    endtask

    function automatic msg_t rand_msg(input int len);
        msg_t m;
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    // ---------------- scoreboard / block sink ----------------
    initial begin
        logic [576:0] e;
        blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || cons_hold) blk_ready = 1'b0;
            else blk_ready = ($urandom_range(0, 3) != 0);
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_block", 512'(blk_valid), 512'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("blk_m", blk_m, e[511:0]);
                    check("blk_t", 512'(blk_t), 512'(e[575:512]));
                    check("blk_final", 512'(blk_final), 512'(e[576]));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        msg_t         m;
        logic [511:0] snap_m;
        logic [63:0]  snap_t;
        logic         snap_f;
        int           cnt;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_blk_m", blk_m, 512'(0));
        check("rst_blk_final", 512'(blk_final), 512'(0));
        check("rst_blk_t", 512'(blk_t), 512'(0));
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 512'(in_ready), 512'(1));
        cons_hold = 1'b0;

        // empty, "abc", 64 bytes (both terminations), 65 bytes
        m = {};
        run_msg(m, 1'b0);
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        run_msg(rand_msg(64), 1'b0);
        run_msg(rand_msg(64), 1'b1);
        m = rand_msg(64);
        m.push_back(8'hAA);
        run_msg(m, 1'b0);

        // randomized messages
        for (int n = 0; n < 30; n++) begin
            int len = $urandom_range(0, 150);
            bit ex  = (len > 0 && len % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_msg(rand_msg(len), ex);
        end

        // sink stalls in EMIT: everything must hold still
        cons_hold = 1'b1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        cnt = 0;
        while (!blk_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        snap_m = blk_m;
        snap_t = blk_t;
        snap_f = blk_final;
        repeat (10) begin
            @(negedge clk);
            check("stall_in_ready", 512'(in_ready), 512'(0));
            check("stall_blk_valid", 512'(blk_valid), 512'(1));
            check("stall_blk_m", blk_m, snap_m);
            check("stall_blk_t", 512'({snap_f, blk_t}), 512'({blk_final, snap_t}));
        end
        cons_hold = 1'b0;
        wait_done();

        // reset while a block is presented
        cons_hold = 1'b1;
        send_msg(rand_msg(20), 1'b0);
        cnt = 0;
        while (!blk_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("emit_rst_blk_valid", 512'(blk_valid), 512'(0));
        check("emit_rst_in_ready", 512'(in_ready), 512'(0));
        reset = 1'b0;
        @(negedge clk);
        cons_hold = 1'b0;
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);

        // reset part way through a block discards the partial data
        for (int k = 0; k < 3; k++) send_word($urandom, 1'b0, 3'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_msg(rand_msg(7), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
